// File: rtl/wb_spi_master.sv
// Wishbone SPI master: single-byte, full-duplex SPI mode-0 transfers.
// Registers: DATA, STATUS, DIV, reserved; SCK half-period is (div+1) clocks.
module wb_spi_master #(
  parameter logic [7:0] CLK_DIV_RST = 8'd1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_stall_o,
  output logic        sck_o,
  output logic        mosi_o,
  input  logic        miso_i,
  output logic        cs_no
);

  typedef enum logic [1:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD
  } state_t;

  state_t state, state_n;

  logic [7:0]  div_q;
  logic [7:0]  div_lat;
  logic [7:0]  div_cnt;
  logic [3:0]  half_cnt;
  logic [7:0]  tx_shift;
  logic [7:0]  rx_shift;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        busy;
  logic        req;
  logic        reject;
  logic        start;
  logic        half_end;
  logic        done;
  logic [1:0]  reg_sel;
  logic [31:0] rd_data;
  logic        unused;

  assign unused     = ^{wb_adr_i[1:0], wb_dat_i[31:8]};
  assign wb_stall_o = 1'b0;
  assign reg_sel    = wb_adr_i[3:2];
  assign req        = wb_cyc_i & wb_stb_i;
  assign busy       = (state != IDLE);
  assign reject     = req & wb_we_i & busy &
                      ((reg_sel == 2'd0) | (reg_sel == 2'd2));
  assign start      = req & wb_we_i & ~busy & (reg_sel == 2'd0);
  assign half_end   = (div_cnt == div_lat);

  always_comb begin
    state_n = state;
    done    = 1'b0;
    unique case (state)
      IDLE:     if (start) state_n = CS_SETUP;
      CS_SETUP: if (half_end) state_n = SHIFT;
      SHIFT: begin
        if (half_end && half_cnt == 4'd15)
          state_n = CS_HOLD;
      end
      CS_HOLD: begin
        if (half_end) begin
          state_n = IDLE;
          done    = 1'b1;
        end
      end
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_n;
  end

  // Both counters restart whenever the FSM changes state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_cnt  <= 8'd0;
      half_cnt <= 4'd0;
    end else if (state_n != state) begin
      div_cnt  <= 8'd0;
      half_cnt <= 4'd0;
    end else if (busy) begin
      if (half_end) begin
        div_cnt  <= 8'd0;
        half_cnt <= half_cnt + 4'd1;
      end else begin
        div_cnt  <= div_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sck_o    <= 1'b0;
      mosi_o   <= 1'b0;
      cs_no    <= 1'b1;
      tx_shift <= 8'd0;
      rx_shift <= 8'd0;
      div_lat  <= 8'd0;
    end else begin
      if (start) begin
        tx_shift <= wb_dat_i[7:0];
        mosi_o   <= wb_dat_i[7];
        cs_no    <= 1'b0;
        div_lat  <= div_q;
      end
      if (state == SHIFT && half_end) begin
        if (half_cnt == 4'd15) begin
          sck_o <= 1'b0;
        end else begin
          sck_o <= ~sck_o;
          if (!sck_o) begin
            rx_shift <= {rx_shift[6:0], miso_i};
          end else begin
            tx_shift <= {tx_shift[6:0], 1'b0};
            mosi_o   <= tx_shift[6];
          end
        end
      end
      if (done) cs_no <= 1'b1;
    end
  end

  always_comb begin
    rd_data = 32'd0;
    unique case (reg_sel)
      2'd0:    rd_data = {24'd0, rx_byte};
      2'd1:    rd_data = {30'd0, rx_valid, busy};
      2'd2:    rd_data = {24'd0, div_q};
      default: rd_data = 32'd0;
    endcase
  end

  // A completing transfer wins over a same-cycle DATA read clearing rx_valid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q    <= CLK_DIV_RST;
      rx_byte  <= 8'd0;
      rx_valid <= 1'b0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= 32'd0;
    end else begin
      wb_ack_o <= req & ~reject;
      wb_err_o <= reject;
      wb_dat_o <= (req & ~wb_we_i) ? rd_data : 32'd0;
      if (req & wb_we_i & ~reject & (reg_sel == 2'd2))
        div_q <= wb_dat_i[7:0];
      if (req & ~wb_we_i & (reg_sel == 2'd0))
        rx_valid <= 1'b0;
      if (done) begin
        rx_valid <= 1'b1;
        rx_byte  <= rx_shift;
      end
    end
  end

endmodule
